circular_dma_ingress_fifo: RTL

- Buffers the AXI-Stream capture data that feeds `circular_dma_fsm`.
- Reports an exact beat occupancy so the FSM can size its AXI bursts.
- Generates `flush_fifo` after the input has been idle at a message boundary, so a partial burst tail is drained instead of stalling.
- Sits between the capture source and the S2MM slave port of the DMA FSM; its outputs connect 1:1 to `s_axis_s2mm_*`, `fifo_occupancy` and `flush_fifo`.

---
 rtl/circular_dma_pkg.sv | 18 +
 rtl/circular_dma_fifo_ram.sv | 35 +++
 rtl/circular_dma_ingress_fifo.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/circular_dma_pkg.sv
// Shared types and constants for the circular DMA ingress path.
package circular_dma_pkg;

    localparam int unsigned C_AXIS_WIDTH     = 64;
    localparam int unsigned C_IDLE_CNT_WIDTH = 32;

    // One stored stream beat; tdata width follows the system AXIS width.
    typedef struct packed {
        logic [C_AXIS_WIDTH-1:0] tdata;
        logic                    tlast;
    } dma_beat_t;

    typedef enum logic [0:0] {
        ST_IDLE_COUNT = 1'b0,
        ST_FLUSH      = 1'b1
    } flush_state_t;

endpackage

// File: rtl/circular_dma_fifo_ram.sv
// Simple dual-port beat storage with a registered (1-cycle) synchronous read port.
module circular_dma_fifo_ram
    import circular_dma_pkg::*;
#(
    parameter int unsigned C_FIFO_DEPTH = 256,
    parameter int unsigned ADDR_WIDTH   = $clog2(C_FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  dma_beat_t             wr_beat,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output dma_beat_t             rd_beat
);

    dma_beat_t mem [C_FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_beat;
        end
    end

    // Read returns the pre-write contents when addresses collide; the caller bypasses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_beat <= '0;
        end else if (rd_en) begin
            rd_beat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/circular_dma_ingress_fifo.sv
// First-word-fall-through capture FIFO in front of the circular DMA FSM, with exact occupancy.
// Optional idle-at-boundary flush generator is compiled in with CIRCULAR_DMA_IDLE_FLUSH_EN.
module circular_dma_ingress_fifo #(
    parameter int unsigned C_AXIS_WIDTH       = circular_dma_pkg::C_AXIS_WIDTH,
    parameter int unsigned C_FIFO_DEPTH       = 256,
    parameter int unsigned C_AXIS_OCCUP_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fifo_clear,
    input  logic [31:0]                   idle_timeout,
    input  logic [C_AXIS_WIDTH-1:0]       s_axis_tdata,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [C_AXIS_WIDTH-1:0]       m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_AXIS_OCCUP_WIDTH-1:0] fifo_occupancy,
    output logic                          flush_fifo,
    output logic                          overflow
);

    import circular_dma_pkg::*;

    localparam int unsigned AW = $clog2(C_FIFO_DEPTH);
    localparam int unsigned OW = C_AXIS_OCCUP_WIDTH;
    localparam logic [OW-1:0] DEPTH_OCC = OW'(C_FIFO_DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [OW-1:0] occ;
    logic [OW-1:0] occ_nxt;
    logic          full;
    logic          push;
    logic          pop;
    logic          ram_wr;
    logic          ram_rd;
    logic          byp_valid;
    dma_beat_t     in_beat;
    dma_beat_t     ram_beat;
    dma_beat_t     byp_beat;
    dma_beat_t     out_beat;

    assign full    = (occ == DEPTH_OCC);
    assign push    = s_axis_tvalid & ~full;
    assign pop     = m_axis_tvalid & m_axis_tready;
    assign in_beat = {s_axis_tdata, s_axis_tlast};
    assign ram_wr  = push & ~fifo_clear;
    assign ram_rd  = (occ_nxt != '0);

    // Next occupancy and read pointer; clear overrides any same-cycle handshake.
    always_comb begin
        occ_nxt    = occ;
        rd_ptr_nxt = rd_ptr + AW'(pop);
        if (fifo_clear) begin
            occ_nxt    = '0;
            rd_ptr_nxt = '0;
        end else if (push && !pop) begin
            occ_nxt = occ + OW'(1);
        end else if (pop && !push) begin
            occ_nxt = occ - OW'(1);
        end
    end

    // The RAM is re-read at the next head address every cycle, so its output register is the head.
    circular_dma_fifo_ram #(
        .C_FIFO_DEPTH (C_FIFO_DEPTH),
        .ADDR_WIDTH   (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_wr),
        .wr_addr (wr_ptr),
        .wr_beat (in_beat),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr_nxt),
        .rd_beat (ram_beat)
    );

    // A beat written to the address being read this edge becomes the head through the bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            s_axis_tready <= 1'b1;
            m_axis_tvalid <= 1'b0;
            overflow      <= 1'b0;
            byp_valid     <= 1'b0;
            byp_beat      <= '0;
        end else begin
            rd_ptr        <= rd_ptr_nxt;
            occ           <= occ_nxt;
            s_axis_tready <= (occ_nxt != DEPTH_OCC);
            m_axis_tvalid <= (occ_nxt != '0);
            byp_valid     <= ram_wr & (wr_ptr == rd_ptr_nxt);
            if (ram_wr) begin
                byp_beat <= in_beat;
            end
            if (fifo_clear) begin
                wr_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (s_axis_tvalid && full) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign out_beat       = byp_valid ? byp_beat : ram_beat;
    assign m_axis_tdata   = out_beat.tdata;
    assign m_axis_tlast   = out_beat.tlast;
    assign fifo_occupancy = occ;

`ifdef CIRCULAR_DMA_IDLE_FLUSH_EN
    flush_state_t                state;
    logic [C_IDLE_CNT_WIDTH-1:0] idle_cnt;
    logic [C_IDLE_CNT_WIDTH-1:0] idle_nxt;
    logic                        boundary;
    logic                        idle_hit;

    // Saturating idle count, only while data waits at a message boundary.
    always_comb begin
        idle_nxt = idle_cnt;
        if (push) begin
            idle_nxt = '0;
        end else if ((occ != '0) && boundary && !(&idle_cnt)) begin
            idle_nxt = idle_cnt + C_IDLE_CNT_WIDTH'(1);
        end
    end

    assign idle_hit = (idle_timeout != '0) && (idle_nxt >= idle_timeout);

    // Flush is held through one cycle at zero occupancy so the FSM can close out its tail burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE_COUNT;
            idle_cnt   <= '0;
            boundary   <= 1'b1;
            flush_fifo <= 1'b0;
        end else if (fifo_clear) begin
            state      <= ST_IDLE_COUNT;
            idle_cnt   <= '0;
            flush_fifo <= 1'b0;
        end else begin
            if (push) begin
                boundary <= s_axis_tlast;
            end
            case (state)
                ST_IDLE_COUNT: begin
                    idle_cnt <= idle_nxt;
                    if (idle_hit) begin
                        state      <= ST_FLUSH;
                        flush_fifo <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (push || (occ == '0)) begin
                        state      <= ST_IDLE_COUNT;
                        idle_cnt   <= '0;
                        flush_fifo <= 1'b0;
                    end
                end
            endcase
        end
    end
`else
    logic unused_idle_timeout;

    assign unused_idle_timeout = ^idle_timeout;
    assign flush_fifo          = 1'b0;
`endif

endmodule
